ddr_tx_serializer: RTL
======================

Name: ddr_tx_serializer

Overview:
- Sequences a pair of DDR output pads: one data pad and one forwarded-clock pad.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, two bits per clock, on the D_OUT_0/D_OUT_1 pair of the data pad.
- Generates the matching D_OUT_0/D_OUT_1 pattern for a forwarded-clock pad, gated to active cycles only.
- Instantiated between a byte-stream source (SPI/QSPI-style flash writer, LED/video bit streamer) and two sb_io_ddr instances.

Parameters:
- WIDTH, 8: word width in bits; must be even and >= 2.
- IDLE_LEVEL, 0: level driven on both data bits when not shifting.
- GAP_CYCLES, 2: idle cycles inserted after a word tagged last, range 0..15.

Ports:
- clock, input, 1: sole clock; also the OUTPUT_CLK of both DDR pads.
- reset_n, input, 1: asynchronous, active-low reset.
- in_data, input, WIDTH: word to transmit.
- in_last, input, 1: word ends a frame; GAP follows it.
- in_valid, input, 1: in_data/in_last valid.
- in_ready, output, 1: block can accept a word this cycle.
- ddr_d0, output, 1: data bit driven on the rising edge (to D_OUT_0).
- ddr_d1, output, 1: data bit driven on the falling edge (to D_OUT_1).
- ddr_clk0, output, 1: forwarded-clock bit, rising half (to clock-pad D_OUT_0).
- ddr_clk1, output, 1: forwarded-clock bit, falling half (to clock-pad D_OUT_1).
- busy, output, 1: word in shifter or holding register, or GAP in progress.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - state=IDLE, holding register empty, counters 0.
  - ddr_d0=ddr_d1=IDLE_LEVEL, ddr_clk0=ddr_clk1=0, busy=0.
  - in_ready=0 while reset_n is low, 1 from the first clock after release.
  - Asserting reset mid-word discards all buffered data; no partial word is completed.
- All outputs are registered. No combinational path from in_* to ddr_*.
- Storage: one shift register plus one holding register (skid).
  - in_ready = holding register empty.
  - Accept occurs when in_valid && in_ready at a rising edge; the word and its last flag go to the holding register.
- States:
  - IDLE: shifter empty. If holding is full, load the shifter from holding (holding empties) and go to SHIFT.
  - SHIFT: pair counter k runs 0..WIDTH/2-1.
    - Each cycle: ddr_d0 = word[WIDTH-1-2k], ddr_d1 = word[WIDTH-2-2k]; ddr_clk0=0, ddr_clk1=1.
    - On the last pair, if the current word is last and GAP_CYCLES>0, go to GAP.
    - Else, if holding is full, reload the shifter in the same cycle (zero-bubble back-to-back) and stay in SHIFT.
    - Else go to IDLE.
  - GAP: drive idle outputs for exactly GAP_CYCLES cycles, then go to IDLE, or reload directly if holding is full.
    - Words may still be accepted into holding during GAP.
- Idle outputs (IDLE and GAP): ddr_d0=ddr_d1=IDLE_LEVEL, ddr_clk0=ddr_clk1=0.
- Latency: a word accepted at edge N from IDLE (with an empty shifter) has its first pair on ddr_d0/d1 after edge N+2. The load happens at N+1; the output register updates at N+2.
- Throughput: one word per WIDTH/2 cycles sustained.
- in_ready may drop for at most WIDTH/2-1 cycles per word while the holding register is full.
- Simultaneous accept and reload in one cycle is legal: holding is read and rewritten in that cycle.
- busy = (state != IDLE) || holding full || output register still showing an active pair. It deasserts in the first cycle the pads are idle.
- in_valid held without acceptance must not change state. Words are never dropped or duplicated.

Test Plan:
- Single word: WIDTH=8, send 0xA5 with last=1 and GAP_CYCLES=2.
  - Output must show (d0,d1)=(1,0),(1,0),(0,1),(0,1) on 4 consecutive cycles, starting 2 cycles after accept.
  - Clock pair must be (0,1) on exactly those 4 cycles, then idle for ≥2 cycles.
  - busy must drop after that.
- Back-to-back: stream 0xFF,0x00,0x3C with in_valid held high and last=0.
  - Output must be 12 consecutive active pairs with no idle cycle.
  - Clock pair must be (0,1) throughout.
  - in_ready must toggle as specified, with exactly 3 accepts.
- Frame gap: send 0x81 (last=1) then 0x81 (last=0) with GAP_CYCLES=3.
  - Exactly 3 idle cycles must separate the two words on the pads.
  - The second word must be accepted during the gap.
- Backpressure randomisation: 200 random bytes with random in_valid gaps.
  - The serialised stream, captured on cycles where clk pair=(0,1), must equal the input sequence bit-exact.
- Reset mid-word: assert reset_n=0 after the 2nd pair of 0xC3.
  - All outputs must go to idle asynchronously, before the next edge.
  - After release, sending 0x0F must produce only 0x0F's pairs; no remnant of 0xC3 may appear.
- IDLE_LEVEL=1, WIDTH=2: send 0b10.
  - Idle cycles must drive (1,1).
  - The single active cycle must drive (1,0).

Source files
------------

// File: rtl/ddr_tx_serializer.sv
// ----------------------------------------------------------------------------
// ddr_tx_serializer
//
// Drives a DDR data pad and a forwarded-clock pad (two sb_io_ddr instances
// clocked by `clock`). Words arrive over a valid/ready handshake into a
// one-entry holding register. They are then shifted out MSB-first, two bits
// per clock. A word tagged `last` is followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clock     - sole clock, also OUTPUT_CLK of both DDR pads
//   reset_n   - asynchronous active-low reset
//   in_data   - word to transmit (WIDTH bits)
//   in_last   - word ends a frame; an idle gap follows it
//   in_valid  - in_data/in_last valid
//   in_ready  - holding register empty, word can be accepted
//   ddr_d0    - data bit for the rising half   (data pad D_OUT_0)
//   ddr_d1    - data bit for the falling half  (data pad D_OUT_1)
//   ddr_clk0  - forwarded clock, rising half   (clock pad D_OUT_0)
//   ddr_clk1  - forwarded clock, falling half  (clock pad D_OUT_1)
//   busy      - word buffered or shifting, gap running, or pads still active
//
// All outputs are registered, so there is no combinational path from in_*
// to the pads.
// ----------------------------------------------------------------------------
module ddr_tx_serializer #(
    parameter int unsigned WIDTH      = 8,     // even, >= 2
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned GAP_CYCLES = 2      // 0..15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ddr_d0,
    output logic             ddr_d1,
    output logic             ddr_clk0,
    output logic             ddr_clk1,
    output logic             busy
);

    localparam int unsigned     PAIRS     = WIDTH / 2;
    localparam int unsigned     CNT_W     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam bit              HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [3:0]      GAP_LAST  = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;

    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic             cur_last_q, cur_last_d;
    logic [CNT_W-1:0] pair_q, pair_d;
    logic [3:0]       gap_q, gap_d;

    logic             d0_q, d0_d;
    logic             d1_q, d1_d;
    logic             clk0_q, clk0_d;
    logic             clk1_q, clk1_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             load;
    logic             last_pair;
    logic             gap_done;

    assign accept    = in_valid && in_ready_q;
    assign last_pair = (pair_q == LAST_PAIR);
    assign gap_done  = (gap_q == GAP_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values that existed before the edge, whatever the order
    // in which the always blocks happen to run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. `load` moves the holding register into the shifter.
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_pair) begin
                    if (cur_last_q && HAS_GAP) begin
                        state_d = ST_GAP;
                    end else if (hold_full_q) begin
                        // Zero-bubble reload: next word starts right after.
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: pad outputs. These feed the output register, so the pads show
    // a pair one cycle after the shifter holds it.
    // ------------------------------------------------------------------
    always_comb begin
        d0_d   = IDLE_LEVEL;
        d1_d   = IDLE_LEVEL;
        clk0_d = 1'b0;
        clk1_d = 1'b0;
        if (state_q == ST_SHIFT) begin
            d0_d   = shift_q[WIDTH-1];
            d1_d   = shift_q[WIDTH-2];
            clk1_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cur_last_d  = cur_last_q;
        pair_d      = pair_q;

        // Reading holding before writing it lets a load and an accept
        // share one cycle.
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_data_d = in_data;
            hold_last_d = in_last;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shift_d    = hold_data_q;
            cur_last_d = hold_last_q;
            pair_d     = '0;
        end else if (state_q == ST_SHIFT) begin
            shift_d = shift_q << 2;
            pair_d  = pair_q + CNT_W'(1);
        end

        gap_d = (state_q == ST_GAP) ? gap_q + 4'd1 : 4'd0;

        // Registered so that busy and in_ready describe the current
        // register contents with no combinational path from the inputs.
        busy_d     = (state_d != ST_IDLE) || hold_full_d || clk1_d;
        in_ready_d = !hold_full_d;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    // NOTE: the data registers are reset as well as the flags, so a reset
    // mid-word leaves nothing behind that could reach the pads later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cur_last_q  <= 1'b0;
            pair_q      <= '0;
            gap_q       <= '0;
            d0_q        <= IDLE_LEVEL;
            d1_q        <= IDLE_LEVEL;
            clk0_q      <= 1'b0;
            clk1_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cur_last_q  <= cur_last_d;
            pair_q      <= pair_d;
            gap_q       <= gap_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            clk0_q      <= clk0_d;
            clk1_q      <= clk1_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ddr_d0   = d0_q;
    assign ddr_d1   = d1_q;
    assign ddr_clk0 = clk0_q;
    assign ddr_clk1 = clk1_q;
    assign busy     = busy_q;

endmodule
